// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer_if
// Brief    : Bus bundle between the PC fetch sequencer and its neighbours
//            (PC adder, branch resolution, instruction memory port).
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;
  logic [31:0] PCAddResult;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        MemAck;
  logic        MemReq;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic [31:0] FetchPC;
  logic        Misaligned;

  modport master (
    input  PCAddResult, Stall, Branch, BranchTarget, MemAck,
    output MemReq, PCResult, FetchValid, FetchPC, Misaligned
  );

  modport slave (
    output PCAddResult, Stall, Branch, BranchTarget, MemAck,
    input  MemReq, PCResult, FetchValid, FetchPC, Misaligned
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Owns the program counter, issues req/ack instruction fetches,
//            handles stall and branch redirect with wrong-path squash.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  pc_fetch_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_pc,       w_pc_nxt;
  logic        r_memreq,   w_memreq_nxt;
  logic        r_fv,       w_fv_nxt;
  logic [31:0] r_fpc,      w_fpc_nxt;
  logic        r_mis,      w_mis_nxt;
  logic        r_pend_vld, w_pend_vld_nxt;
  logic [31:0] r_pend_tgt, w_pend_tgt_nxt;

  logic        w_apply;
  logic [31:0] w_tgt_raw;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_memreq   <= 1'b0;
      r_fv       <= 1'b0;
      r_fpc      <= 32'h0;
      r_mis      <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_memreq   <= w_memreq_nxt;
      r_fv       <= w_fv_nxt;
      r_fpc      <= w_fpc_nxt;
      r_mis      <= w_mis_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fv_nxt       = 1'b0;
    w_fpc_nxt      = r_fpc;
    w_mis_nxt      = 1'b0;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_tgt_nxt = r_pend_tgt;
    w_apply        = 1'b0;
    w_tgt_raw      = bus.BranchTarget;

    case (r_state)
      ST_REQ: begin
        if (!bus.MemAck) begin
          // Request stays up and PC frozen; remember the newest redirect.
          if (bus.Branch) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_tgt_nxt = bus.BranchTarget;
          end
        end else begin
          if (bus.Branch) begin
            w_apply = 1'b1;
          end else if (r_pend_vld) begin
            w_apply   = 1'b1;
            w_tgt_raw = r_pend_tgt;
          end else begin
            w_fv_nxt  = 1'b1;
            w_fpc_nxt = r_pc;
            w_pc_nxt  = bus.PCAddResult;
          end
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = bus.Stall ? ST_HOLD : ST_REQ;
        end
      end
      default: begin
        // BOOT and HOLD: nothing outstanding, so a redirect lands at once.
        w_apply     = bus.Branch;
        w_state_nxt = bus.Stall ? ST_HOLD : ST_REQ;
      end
    endcase

    if (w_apply) begin
      w_pc_nxt  = {w_tgt_raw[31:2], 2'b00};
      w_mis_nxt = |w_tgt_raw[1:0];
    end

    w_memreq_nxt = (w_state_nxt == ST_REQ);
  end

  assign bus.MemReq     = r_memreq;
  assign bus.PCResult   = r_pc;
  assign bus.FetchValid = r_fv;
  assign bus.FetchPC    = r_fpc;
  assign bus.Misaligned = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Self-checking bench for pc_fetch_sequencer against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h00000000;

  logic Clk;
  logic Reset;
  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_VECTOR(RESET_VECTOR)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // External PC adder
  assign bus.PCAddResult = bus.PCResult + 32'd4;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: PC, whether a request is outstanding, redirects waiting.
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_fv;
  logic [31:0] m_fpc;
  logic        m_mis;
  logic [31:0] pend_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RESET_VECTOR;
    m_req = 1'b0;
    m_fv  = 1'b0;
    m_fpc = 32'h0;
    m_mis = 1'b0;
    pend_q.delete();
  endtask

  task automatic model_redirect(input logic [31:0] t);
    m_pc  = t & 32'hFFFF_FFFC;
    m_mis = (t[1:0] != 2'b00);
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] bt, input logic ack);
    m_fv  = 1'b0;
    m_mis = 1'b0;
    if (!m_req) begin
      if (br) model_redirect(bt);
      m_req = !st;
    end else if (!ack) begin
      if (br) pend_q.push_back(bt);
    end else begin
      if (br) model_redirect(bt);
      else if (pend_q.size() != 0) model_redirect(pend_q[$]);
      else begin
        m_fv  = 1'b1;
        m_fpc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
      pend_q.delete();
      m_req = !st;
    end
  endtask

  task automatic compare_all();
    chk("MemReq",     {31'h0, bus.MemReq},     {31'h0, m_req});
    chk("PCResult",   bus.PCResult,            m_pc);
    chk("FetchValid", {31'h0, bus.FetchValid}, {31'h0, m_fv});
    chk("FetchPC",    bus.FetchPC,             m_fpc);
    chk("Misaligned", {31'h0, bus.Misaligned}, {31'h0, m_mis});
  endtask

  // Drive at negedge, let the DUT and model both take the edge, check at negedge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] bt, input logic ack);
    bus.Stall        = st;
    bus.Branch       = br;
    bus.BranchTarget = bt;
    bus.MemAck       = ack;
    @(posedge Clk);
    model_step(st, br, bt, ack);
    @(negedge Clk);
    compare_all();
  endtask

  // Reset asserted mid-cycle; MemReq must fall without waiting for an edge.
  task automatic apply_reset();
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    chk("rst_MemReq",   {31'h0, bus.MemReq},   32'h0);
    chk("rst_PCResult", bus.PCResult,          RESET_VECTOR);
    chk("rst_FValid",   {31'h0, bus.FetchValid}, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
    Reset = 1'b0;
  endtask

  initial begin
    bus.Stall        = 1'b0;
    bus.Branch       = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.MemAck       = 1'b0;
    Reset            = 1'b0;
    model_reset();
    @(negedge Clk);
    apply_reset();

    // Sequential fetch with ack tied high
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("seq_pc", bus.PCResult, 32'h00000010);

    // Wraparound at top of address space
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_fpc", bus.FetchPC, 32'hFFFF_FFFC);
    chk("wrap_pc",  bus.PCResult, 32'h0);
    chk("wrap_mis", {31'h0, bus.Misaligned}, 32'h0);

    // Pending redirect while ack is withheld, then squash on ack
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_03E8, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pend_pc", bus.PCResult, 32'h0000_03E8);
    chk("pend_fv", {31'h0, bus.FetchValid}, 32'h0);

    // Misaligned redirect while stalled in HOLD
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0112, 1'b0);
    chk("mis_pc",  bus.PCResult, 32'h0000_0110);
    chk("mis_flag", {31'h0, bus.Misaligned}, 32'h1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_pulse", {31'h0, bus.Misaligned}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset while a request is outstanding with a redirect pending
    cycle(1'b0, 1'b1, 32'h0000_0500, 1'b0);
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Branch coincident with ack
    cycle(1'b0, 1'b1, 32'hFFFF_0000, 1'b1);
    chk("brack_pc", bus.PCResult, 32'hFFFF_0000);
    chk("brack_fv", {31'h0, bus.FetchValid}, 32'h0);
    chk("brack_req", {31'h0, bus.MemReq}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            $urandom,
            ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 149) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

- Owns the architectural program counter and issues instruction-fetch requests.
- Drives `PCResult` into the PC adder and consumes its `PCAddResult` (= `PCResult` + 4, computed externally) as the sequential next PC.
- Handles stall, branch redirect with squash of wrong-path fetches, and a req/ack handshake to instruction memory.
- Sits between the PC adder, branch resolution logic and the instruction memory port.

## Interface
- `RESET_VECTOR`, default 32'h00000000: value loaded into `PCResult` on reset.
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PCAddResult`  in  32  sequential next PC from the PC adder.
- `Stall`  in  1  when high, no new fetch request is started.
- `Branch`  in  1  one-cycle redirect strobe.
- `BranchTarget`  in  32  redirect address, valid while `Branch` = 1.
- `MemAck`  in  1  instruction memory accepts the current request this cycle.
- `MemReq`  out  1  fetch request; address is `PCResult`.
- `PCResult`  out  32  current PC and fetch address.
- `FetchValid`  out  1  one-cycle pulse: fetch at `FetchPC` completed on the correct path.
- `FetchPC`  out  32  address of the completed fetch.
- `Misaligned`  out  1  one-cycle pulse: an applied redirect target had nonzero bits [1:0].

## Operation
- Clock `Clk`; reset `Reset` is asynchronous and active-high.
- Reset (async) values:
  - `PCResult` = RESET_VECTOR
  - `MemReq`, `FetchValid`, `Misaligned`, redirect-pending = 0
  - `FetchPC` = 0
  - state = BOOT
- All outputs are registered. `MemReq` is decoded from state: 1 in REQ only.
- State BOOT (one cycle after reset release):
  - Stall=1 -> HOLD, else -> REQ.
  - Branch in BOOT is applied as in HOLD.
- State REQ: `MemReq`=1; `PCResult` holds constant until the ack cycle. A request is never withdrawn before ack.
  - No ack, Branch=1: store `BranchTarget` in redirect-pending register (latest Branch wins); stay REQ.
  - Ack, no redirect (neither Branch this cycle nor pending):
    - `FetchValid`<=1, `FetchPC`<=`PCResult`, `PCResult`<=`PCAddResult`.
  - Ack with redirect (Branch this cycle takes priority over pending):
    - `FetchValid`<=0 (squash), `PCResult`<=target, pending cleared.
  - After ack: Stall=1 -> HOLD, else stay REQ, issuing the next request back-to-back (`MemReq` stays 1, address changes).
- State HOLD: `MemReq`=0; no outstanding request.
  - Branch=1: `PCResult`<=`BranchTarget` immediately.
  - Stall=0 -> REQ.
- Applying any redirect target:
  - Bits [1:0] are forced to 0.
  - If the original bits [1:0]!=0, `Misaligned` pulses for one cycle.
- Arithmetic: no internal adder. `PCAddResult` is taken as-is, so 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
- Stall raised while in REQ does not cancel the outstanding request; it takes effect only after ack.

## Timing
- Fetch latency:
  - `MemReq` rises on the first edge after entering REQ.
  - With ack in the same cycle, `FetchValid` is high the following cycle, for exactly one cycle.
  - Sustained throughput: one fetch per cycle when `MemAck` is held high.
- Redirect latency:
  - HOLD: new `PCResult` on the edge after Branch.
  - REQ: new `PCResult` on the edge of the ack cycle.
- `FetchValid` and `Misaligned` are never high two cycles in a row from a single event.
- Reset mid-request:
  - `MemReq` drops asynchronously.
  - Pending redirect and in-flight fetch are discarded; no `FetchValid`.
- Branch and ack in the same cycle: Branch target wins; the acked fetch is squashed.

## Test plan
- Reset, RESET_VECTOR=0, MemAck tied 1 -> `PCResult` steps 0, 4, 8, C; `FetchValid` pulses with `FetchPC` 0, 4, 8.
- `PCResult`=32'hFFFFFFFC, ack -> `FetchPC`=FFFFFFFC, next `PCResult`=00000000, no flag.
- In REQ, hold MemAck=0 for 3 cycles, pulse Branch with target 32'h000003E8, then ack -> `PCResult` constant until ack, then 3E8; `FetchValid` stays 0 for the squashed fetch.
- Stall=1 in HOLD, Branch target 32'h00000112 -> `PCResult`=00000110, `Misaligned` one-cycle pulse, `MemReq`=0 until Stall falls.
- Assert Reset while `MemReq`=1 and a redirect is pending -> `MemReq`=0 immediately; after release `PCResult`=RESET_VECTOR and no `FetchValid` is produced.
- Branch in the same cycle as ack, target 32'hFFFF0000 -> `FetchValid`=0, `PCResult`=FFFF0000, next request issued back-to-back.
